// File: rtl/arm_pipeline_pkg.sv
// Shared types and constants for the ARM968E-S pipeline stages.
// Holds the fetch FSM encoding, the PC next-value select and fetch constants.
package arm_pipeline_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'b00,
        HOLD    = 2'b01,
        DISCARD = 2'b10
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_SEL_INC     = 2'b00,
        PC_SEL_BRANCH  = 2'b01,
        PC_SEL_PENDING = 2'b10
    } pc_sel_t;

    localparam logic [31:0] NOP_INSTR = 32'h0;
    localparam int unsigned PC_INC    = 4;

endpackage

// File: rtl/if_fetch_unit_pc_register.sv
// Program counter for the fetch stage: selects the next fetch address and
// loads it on request; asynchronous active-low reset to RESET_PC.
module pc_register
    import arm_pipeline_pkg::*;
#(
    parameter int                     ADDRESS_LEN = 32,
    parameter logic [ADDRESS_LEN-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  pc_sel_t                sel,
    input  logic [ADDRESS_LEN-1:0] branch_addr,
    input  logic [ADDRESS_LEN-1:0] pending_addr,
    output logic [ADDRESS_LEN-1:0] pc,
    output logic [ADDRESS_LEN-1:0] pc_plus4
);

    logic [ADDRESS_LEN-1:0] pc_next;

    // Increment wraps modulo 2^ADDRESS_LEN.
    assign pc_plus4 = pc + ADDRESS_LEN'(PC_INC);

    always_comb begin
        pc_next = pc_plus4;
        case (sel)
            PC_SEL_BRANCH:  pc_next = branch_addr;
            PC_SEL_PENDING: pc_next = pending_addr;
            default:        pc_next = pc_plus4;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a request/ready instruction
// memory port and presents instructions or bubbles to the IF/ID register.
module if_fetch_unit
    import arm_pipeline_pkg::*;
#(
    parameter int                     ADDRESS_LEN = 32,
    parameter int                     DATA_LEN    = 32,
    parameter logic [ADDRESS_LEN-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   freeze,
    input  logic                   branch_taken,
    input  logic [ADDRESS_LEN-1:0] branch_addr,
    output logic                   imem_req,
    output logic [ADDRESS_LEN-1:0] imem_addr,
    input  logic                   imem_ready,
    input  logic [DATA_LEN-1:0]    imem_rdata,
    output logic [ADDRESS_LEN-1:0] PC,
    output logic [DATA_LEN-1:0]    Instruction,
    output logic                   instr_valid
);

    fetch_state_t           state;
    fetch_state_t           next_state;
    pc_sel_t                pc_sel;
    logic                   pc_load;
    logic                   hold_load;
    logic                   pend_load;
    logic [ADDRESS_LEN-1:0] pc_reg;
    logic [ADDRESS_LEN-1:0] pc_plus4;
    logic [ADDRESS_LEN-1:0] branch_word;
    logic [ADDRESS_LEN-1:0] pending_target;
    logic [ADDRESS_LEN-1:0] hold_pc;
    logic [DATA_LEN-1:0]    hold_buf;

    assign branch_word = branch_addr & ~ADDRESS_LEN'(3);
    assign imem_addr   = pc_reg;

    pc_register #(
        .ADDRESS_LEN (ADDRESS_LEN),
        .RESET_PC    (RESET_PC)
    ) u_pc_register (
        .clk          (clk),
        .rst          (rst),
        .load         (pc_load),
        .sel          (pc_sel),
        .branch_addr  (branch_word),
        .pending_addr (pending_target),
        .pc           (pc_reg),
        .pc_plus4     (pc_plus4)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Data-only registers; their contents are never observed before being loaded.
    always_ff @(posedge clk) begin
        if (hold_load) begin
            hold_buf <= imem_rdata;
            hold_pc  <= pc_plus4;
        end
        if (pend_load) begin
            pending_target <= branch_word;
        end
    end

    always_comb begin
        next_state  = state;
        pc_load     = 1'b0;
        pc_sel      = PC_SEL_INC;
        hold_load   = 1'b0;
        pend_load   = 1'b0;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        PC          = '0;
        Instruction = DATA_LEN'(NOP_INSTR);

        // Outputs stay at the bubble value for as long as reset is asserted.
        if (rst) begin
            case (state)
                FETCH: begin
                    imem_req = 1'b1;
                    if (branch_taken) begin
                        if (imem_ready) begin
                            pc_load = 1'b1;
                            pc_sel  = PC_SEL_BRANCH;
                        end else begin
                            pend_load  = 1'b1;
                            next_state = DISCARD;
                        end
                    end else if (imem_ready) begin
                        pc_load = 1'b1;
                        pc_sel  = PC_SEL_INC;
                        if (freeze) begin
                            hold_load  = 1'b1;
                            next_state = HOLD;
                        end else begin
                            instr_valid = 1'b1;
                            PC          = pc_plus4;
                            Instruction = imem_rdata;
                        end
                    end
                end

                HOLD: begin
                    if (branch_taken) begin
                        pc_load    = 1'b1;
                        pc_sel     = PC_SEL_BRANCH;
                        next_state = FETCH;
                    end else begin
                        instr_valid = 1'b1;
                        PC          = hold_pc;
                        Instruction = hold_buf;
                        if (!freeze) begin
                            next_state = FETCH;
                        end
                    end
                end

                DISCARD: begin
                    imem_req = 1'b1;
                    if (branch_taken) begin
                        pend_load = 1'b1;
                    end
                    if (imem_ready) begin
                        pc_load    = 1'b1;
                        pc_sel     = branch_taken ? PC_SEL_BRANCH : PC_SEL_PENDING;
                        next_state = FETCH;
                    end
                end

                default: begin
                    next_state = FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a queue-style reference model of the
// fetch stream and a wait-state instruction memory.
module tb_if_fetch_unit;

    localparam logic [31:0] RST_PC  = 32'h0;
    localparam logic [31:0] SPECIAL = 32'hE3A01005;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] PC;
    logic [31:0] Instruction;
    logic        instr_valid;

    int          total = 0;
    int          bad   = 0;
    int          wait_cfg = 0;
    int          wait_cnt;
    logic [31:0] salt = 32'h0;
    logic        special_en = 1'b0;

    // reference model state (m_) and next state (n_)
    logic [31:0] m_addr = RST_PC, n_addr = RST_PC;
    logic        m_held = 1'b0,   n_held = 1'b0;
    logic [31:0] m_hins = 32'h0,  n_hins = 32'h0;
    logic [31:0] m_hpc  = 32'h0,  n_hpc  = 32'h0;
    logic        m_redir = 1'b0,  n_redir = 1'b0;
    logic [31:0] m_tgt  = 32'h0,  n_tgt  = 32'h0;

    if_fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .PC           (PC),
        .Instruction  (Instruction),
        .instr_valid  (instr_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] s,
                                             input logic sp);
        if (sp && a == 32'h8) return SPECIAL;
        return a + s;
    endfunction

    assign imem_rdata = mem_word(imem_addr, salt, special_en);
    assign imem_ready = imem_req && (wait_cnt >= wait_cfg);

    always @(posedge clk or negedge rst) begin
        if (!rst)                       wait_cnt <= 0;
        else if (imem_req && !imem_ready) wait_cnt <= wait_cnt + 1;
        else                            wait_cnt <= 0;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model step and per-cycle comparison, evaluated mid-cycle on stable inputs.
    initial forever begin
        logic [31:0] e_pc, e_ins, ba;
        logic        e_v, e_req;
        @(negedge clk);
        e_pc = 0; e_ins = 0; e_v = 0; e_req = 0;
        ba = {branch_addr[31:2], 2'b00};
        n_addr = m_addr; n_held = m_held; n_hins = m_hins; n_hpc = m_hpc;
        n_redir = m_redir; n_tgt = m_tgt;
        if (!rst) begin
            n_addr = RST_PC; n_held = 0; n_redir = 0;
        end else if (m_held) begin
            if (branch_taken) begin
                n_held = 0; n_addr = ba;
            end else begin
                e_v = 1; e_pc = m_hpc; e_ins = m_hins;
                if (!freeze) n_held = 0;
            end
        end else begin
            e_req = 1;
            if (imem_ready) begin
                if (m_redir || branch_taken) begin
                    n_redir = 0;
                    n_addr  = branch_taken ? ba : m_tgt;
                end else if (freeze) begin
                    n_held = 1;
                    n_hins = mem_word(m_addr, salt, special_en);
                    n_hpc  = m_addr + 32'd4;
                    n_addr = m_addr + 32'd4;
                end else begin
                    e_v = 1; e_pc = m_addr + 32'd4;
                    e_ins = mem_word(m_addr, salt, special_en);
                    n_addr = m_addr + 32'd4;
                end
            end else if (branch_taken) begin
                n_redir = 1; n_tgt = ba;
            end
        end
        chk("cyc_req", {31'b0, imem_req}, {31'b0, e_req});
        chk("cyc_valid", {31'b0, instr_valid}, {31'b0, e_v});
        chk("cyc_pc", PC, e_pc);
        chk("cyc_instr", Instruction, e_ins);
        if (e_req) chk("cyc_addr", imem_addr, m_addr);
    end

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            m_addr = RST_PC; m_held = 0; m_redir = 0;
        end else begin
            m_addr = n_addr; m_held = n_held; m_hins = n_hins; m_hpc = n_hpc;
            m_redir = n_redir; m_tgt = n_tgt;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;

        // reset state, then zero-wait stream with rdata = address
        @(negedge clk);
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_pc", PC, 32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'h0);
        next_cycle(); rst = 1'b1;
        @(negedge clk); chk("zw_pc0", PC, 32'd4);  chk("zw_in0", Instruction, 32'd0);
        chk("zw_v0", {31'b0, instr_valid}, 32'd1);
        @(negedge clk); chk("zw_pc1", PC, 32'd8);  chk("zw_in1", Instruction, 32'd4);
        @(negedge clk); chk("zw_pc2", PC, 32'd12); chk("zw_in2", Instruction, 32'd8);

        // three wait states per fetch
        next_cycle(); rst = 1'b0; wait_cfg = 3; salt = 32'h1000_0000;
        next_cycle(); rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ws_addr", imem_addr, 32'h0);
            chk("ws_bubble", {31'b0, instr_valid}, 32'h0);
            if (i < 2) next_cycle();
        end
        next_cycle();
        @(negedge clk); chk("ws_addr3", imem_addr, 32'h0); chk("ws_pc", PC, 32'd4);
        chk("ws_instr", Instruction, 32'h1000_0000);
        next_cycle();
        @(negedge clk); chk("ws_next_addr", imem_addr, 32'd4);

        // freeze capture of the word at address 8
        next_cycle(); rst = 1'b0; wait_cfg = 0; special_en = 1'b1;
        next_cycle(); rst = 1'b1;
        next_cycle();
        next_cycle(); freeze = 1'b1;
        @(negedge clk); chk("fz_cap_v", {31'b0, instr_valid}, 32'h0);
        chk("fz_cap_addr", imem_addr, 32'h8);
        next_cycle();
        @(negedge clk); chk("fz_hold_req", {31'b0, imem_req}, 32'h0);
        chk("fz_hold_pc", PC, 32'd12); chk("fz_hold_in", Instruction, SPECIAL);
        next_cycle();
        next_cycle(); freeze = 1'b0;
        @(negedge clk); chk("fz_rel_v", {31'b0, instr_valid}, 32'h1);
        chk("fz_rel_in", Instruction, SPECIAL);
        next_cycle();
        @(negedge clk); chk("fz_next_addr", imem_addr, 32'd12);
        chk("fz_next_pc", PC, 32'd16);

        // branch with outstanding request, then latest-wins redirect
        next_cycle(); rst = 1'b0; special_en = 1'b0;
        next_cycle(); rst = 1'b1;
        repeat (7) next_cycle();
        next_cycle(); wait_cfg = 2; branch_taken = 1'b1; branch_addr = 32'h100;
        @(negedge clk); chk("br_addr0", imem_addr, 32'h20);
        next_cycle(); branch_taken = 1'b0;
        @(negedge clk); chk("br_addr1", imem_addr, 32'h20);
        next_cycle();
        @(negedge clk); chk("br_drop_v", {31'b0, instr_valid}, 32'h0);
        chk("br_addr2", imem_addr, 32'h20);
        next_cycle(); branch_taken = 1'b1; branch_addr = 32'h180;
        @(negedge clk); chk("br_tgt1", imem_addr, 32'h100);
        next_cycle(); branch_addr = 32'h203;
        next_cycle(); branch_taken = 1'b0;
        next_cycle();
        @(negedge clk); chk("br_latest", imem_addr, 32'h200);
        next_cycle();
        next_cycle();
        @(negedge clk); chk("br_pc", PC, 32'h204); chk("br_in", Instruction, 32'h1000_0200);

        // branch beats freeze while holding
        next_cycle(); wait_cfg = 0; freeze = 1'b1;
        next_cycle(); branch_taken = 1'b1; branch_addr = 32'h40;
        @(negedge clk); chk("bf_req", {31'b0, imem_req}, 32'h0);
        chk("bf_v", {31'b0, instr_valid}, 32'h0);
        next_cycle(); branch_taken = 1'b0; freeze = 1'b0;
        @(negedge clk); chk("bf_addr", imem_addr, 32'h40); chk("bf_pc", PC, 32'h44);

        // asynchronous reset while a request is outstanding
        next_cycle(); wait_cfg = 3;
        #2 rst = 1'b0;
        #1 chk("ar_req", {31'b0, imem_req}, 32'h0); chk("ar_pc", PC, 32'h0);
        chk("ar_in", Instruction, 32'h0);
        next_cycle(); rst = 1'b1; wait_cfg = 0;
        @(negedge clk); chk("ar_addr", imem_addr, RST_PC); chk("ar_pc4", PC, 32'd4);

        next_cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
